// File: rtl/stream_uart_tx.sv
// stream_uart_tx: valid/ready byte stream into a small FIFO, serialised as
// 8N1 UART frames on a registered, idle-high tx line.
module stream_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 417,
   parameter int unsigned FIFO_ADDR_W  = 4
) (
   input  logic                   clk_48mhz,
   input  logic                   reset,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   tx,
   output logic                   busy,
   output logic [FIFO_ADDR_W:0]   fifo_level
);

   localparam logic [FIFO_ADDR_W:0] FULL_CNT    = {1'b1, {FIFO_ADDR_W{1'b0}}};
   localparam logic [15:0]          BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   logic [7:0]             mem_q [0:(1 << FIFO_ADDR_W) - 1];
   logic [FIFO_ADDR_W-1:0] wr_ptr_q;
   logic [FIFO_ADDR_W-1:0] rd_ptr_q;
   logic [FIFO_ADDR_W:0]   count_q;
   logic                   push;
   logic                   pop;
   logic                   fifo_empty;

   state_t                 state_q, state_d;
   logic [15:0]            baud_q, baud_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             shift_q, shift_d;
   logic                   tx_q, tx_d;

   // Full is judged from the registered count only, so a pop in the same
   // cycle never lets a write through at full.
   assign in_ready   = ~reset & (count_q != FULL_CNT);
   assign push       = in_valid & in_ready;
   assign fifo_empty = (count_q == '0);

   assign tx         = tx_q;
   assign busy       = (state_q != S_IDLE) | ~fifo_empty;
   assign fifo_level = count_q;

   // FIFO storage; contents need no reset since the count gates every read.
   always_ff @(posedge clk_48mhz) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   // FIFO pointers and occupancy count.
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + FIFO_ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + FIFO_ADDR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + (FIFO_ADDR_W + 1)'(1);
            2'b01:   count_q <= count_q - (FIFO_ADDR_W + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Serialiser state register.
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // Serialiser next state: each bit lasts CLKS_PER_BIT cycles, ending when
   // the baud down-counter reaches zero.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               tx_d    = 1'b0;
               bit_d   = '0;
               baud_d  = BAUD_RELOAD;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_q == '0) begin
               tx_d    = shift_q[0];
               baud_d  = BAUD_RELOAD;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         S_DATA: begin
            if (baud_q == '0) begin
               baud_d = BAUD_RELOAD;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         S_STOP: begin
            if (baud_q == '0) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  tx_d    = 1'b0;
                  bit_d   = '0;
                  baud_d  = BAUD_RELOAD;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_stream_uart_tx.sv
// Self-checking bench for stream_uart_tx: accepted bytes go to a scoreboard
// queue, a tx-line decoder pops and compares each received frame.
module tb_stream_uart_tx;

   localparam int unsigned CPB = 4;
   localparam int unsigned FW  = 10 * CPB;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic [7:0] in_data  = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       tx;
   logic       busy;
   logic [4:0] fifo_level;

   int         total  = 0;
   int         bad    = 0;
   int         frames = 0;
   logic [7:0] sb [$];

   always #5 clk = ~clk;

   stream_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_ADDR_W  (4)
   ) dut (
      .clk_48mhz  (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   // tx decoder: samples mid-bit on the falling clock edge, checks each
   // frame against the scoreboard head.
   bit         mon_active = 1'b0;
   int         mon_cnt    = 0;
   logic [9:0] mon_bits   = '0;
   logic [7:0] mon_exp;

   always @(negedge clk) begin
      if (reset) begin
         mon_active = 1'b0;
      end else begin
         if (!mon_active && tx === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
         end
         if (mon_active) begin
            if (mon_cnt % CPB == CPB / 2) mon_bits[mon_cnt / CPB] = tx;
            if (mon_cnt == 9 * CPB + CPB / 2) begin
               mon_active = 1'b0;
               frames++;
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL mon_unexpected: frame %b decoded, scoreboard empty", mon_bits);
               end else begin
                  mon_exp = sb.pop_front();
                  if (mon_bits !== {1'b1, mon_exp, 1'b0}) begin
                     bad++;
                     $display("FAIL mon_frame: got %b, want %b", mon_bits, {1'b1, mon_exp, 1'b0});
                  end
               end
            end
            mon_cnt++;
         end
      end
   end

   function automatic logic [FW-1:0] frame_bits(input logic [7:0] b);
      logic [9:0]    f;
      logic [FW-1:0] r;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < FW; i++) r[i] = f[i / CPB];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int limit);
      for (int i = 0; i < limit && busy !== 1'b0; i++) tick();
      total++;
      if (busy !== 1'b0 || sb.size() != 0) begin
         bad++;
         $display("FAIL drain: busy=%b sb_left=%0d, want busy=0 sb_left=0", busy, sb.size());
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (3) tick();
      total++; if (tx !== 1'b1)        begin bad++; $display("FAIL rst_tx: got %b want 1", tx); end
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
      total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL rst_ready: got %b want 0", in_ready); end
      reset = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_ready_after: got %b want 1", in_ready); end
   endtask

   task automatic test_single();
      logic [FW-1:0] txv, busyv;
      tick();
      in_data  = 8'h55;
      in_valid = 1'b1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", in_ready); end
      if (in_ready) sb.push_back(8'h55);
      tick();
      in_valid = 1'b0;
      total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL single_level: got %0d want 1", fifo_level); end
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_tx_accept_edge: got %b want 1", tx); end
      tick();
      for (int i = 0; i < FW; i++) begin
         txv[i]   = tx;
         busyv[i] = busy;
         tick();
      end
      total++; if (txv !== frame_bits(8'h55)) begin bad++; $display("FAIL single_frame: got %b want %b", txv, frame_bits(8'h55)); end
      total++; if (busyv !== '1) begin bad++; $display("FAIL single_busy_high: got %b want all ones", busyv); end
      total++; if (busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL single_end: busy=%b tx=%b want busy=0 tx=1", busy, tx); end
      wait_idle(10);
   endtask

   task automatic test_back_to_back();
      logic [2*FW-1:0] txv;
      tick();
      in_valid = 1'b1;
      in_data  = 8'h00;
      if (in_ready) sb.push_back(8'h00);
      tick();
      in_data = 8'hFF;
      if (in_ready) sb.push_back(8'hFF);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 2 * FW; i++) begin
         txv[i] = tx;
         tick();
      end
      total++;
      if (txv !== {frame_bits(8'hFF), frame_bits(8'h00)}) begin
         bad++;
         $display("FAIL b2b_frames: got %b want %b", txv, {frame_bits(8'hFF), frame_bits(8'h00)});
      end
      total++; if (busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL b2b_end: busy=%b tx=%b want busy=0 tx=1", busy, tx); end
      wait_idle(10);
   endtask

   task automatic test_full_fifo();
      logic [7:0] d = 8'h01;
      int         nacc = 0;
      int         ready_step = -1;
      tick();
      for (int i = 0; i < 100 && d <= 8'h12; i++) begin
         in_valid = 1'b1;
         in_data  = d;
         if (in_ready) begin
            sb.push_back(d);
            if (d == 8'h12) ready_step = i;
            d = d + 8'd1;
            nacc++;
         end
         tick();
         if (i == 16) begin
            total++; if (nacc != 17) begin bad++; $display("FAIL full_transfers: got %0d want 17", nacc); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", in_ready); end
            total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_level: got %0d want 16", fifo_level); end
         end
      end
      in_valid = 1'b0;
      total++; if (ready_step != FW + 2) begin bad++; $display("FAIL full_reready_step: got %0d want %0d", ready_step, FW + 2); end
      total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_level_refill: got %0d want 16", fifo_level); end
      wait_idle(20 * FW);
   endtask

   task automatic test_backpressure();
      bit         level_ok = 1'b1;
      bit         got = 1'b0;
      int         nfill = 0;
      logic [7:0] d;
      tick();
      for (int k = 0; k < 17; k++) begin
         in_valid = 1'b1;
         in_data  = 8'h30 + 8'(k);
         if (in_ready) begin
            sb.push_back(in_data);
            nfill++;
         end
         tick();
      end
      total++; if (nfill != 17) begin bad++; $display("FAIL bp_fill: got %0d want 17", nfill); end
      for (int j = 0; j < 100 && !got; j++) begin
         d        = 8'hA0 + 8'(j);
         in_data  = d;
         in_valid = 1'b1;
         if (in_ready) begin
            sb.push_back(d);
            got = 1'b1;
         end else if (fifo_level !== 5'd16) begin
            level_ok = 1'b0;
         end
         tick();
      end
      in_valid = 1'b0;
      total++; if (!level_ok || !got) begin bad++; $display("FAIL bp_hold: level_ok=%b accepted=%b want 1 1", level_ok, got); end
      total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL bp_level: got %0d want 16", fifo_level); end
      wait_idle(20 * FW);
   endtask

   task automatic test_ordering();
      logic [7:0] bytes [64];
      int         idx = 0;
      int         f0;
      f0 = frames;
      for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom_range(0, 255));
      tick();
      for (int c = 0; c < 6000 && idx < 64; c++) begin
         if ($urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_data  = bytes[idx];
            if (in_ready) begin
               sb.push_back(bytes[idx]);
               idx++;
            end
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      in_valid = 1'b0;
      total++; if (idx != 64) begin bad++; $display("FAIL order_accept: got %0d want 64", idx); end
      wait_idle(20 * FW);
      total++; if (frames - f0 != 64) begin bad++; $display("FAIL order_frames: got %0d want 64", frames - f0); end
   endtask

   task automatic test_reset_mid();
      bit tx_ok = 1'b1;
      int f0;
      tick();
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = 8'h11 + 8'(k);
         if (in_ready) sb.push_back(in_data);
         tick();
      end
      in_valid = 1'b0;
      repeat (14) tick();
      reset = 1'b1;
      sb.delete();
      tick();
      reset = 1'b0;
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL rmid_tx: got %b want 1", tx); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL rmid_level: got %0d want 0", fifo_level); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
      f0 = frames;
      for (int i = 0; i < 3 * FW; i++) begin
         if (tx !== 1'b1) tx_ok = 1'b0;
         tick();
      end
      total++; if (!tx_ok || frames != f0) begin bad++; $display("FAIL rmid_quiet: tx_stayed_high=%b new_frames=%0d want 1 0", tx_ok, frames - f0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full_fifo();
      test_backpressure();
      test_ordering();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_uart_tx.md
# stream_uart_tx

Byte-stream to physical UART transmitter. It accepts bytes on a valid/ready byte pipeline, identical in handshake to the USB serial core's `uart_out_*` stream, and buffers them in a small FIFO. It serialises them as 8N1 frames on a single TX pin. It sits between the USB serial core and an external UART, forming the host-to-device half of a USB-to-UART bridge in the `clk_48mhz` domain.

## Interface
Parameters:
- `CLKS_PER_BIT`, 417: clock cycles per UART bit; 48 MHz / 417 gives 115107 baud. Legal range 2..65535.
- `FIFO_ADDR_W`, 4: log2 of FIFO depth; depth = 2^FIFO_ADDR_W = 16.

Ports:
- `clk_48mhz`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `in_data`, in, 8: byte to transmit.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: block can accept a byte this cycle.
- `tx`, out, 1: UART line, idle high, registered.
- `busy`, out, 1: a frame is in progress or the FIFO is non-empty.
- `fifo_level`, out, FIFO_ADDR_W+1: current FIFO occupancy, 0..16.

## Operation
- Transfer occurs on a rising edge where `in_valid & in_ready`. The byte is written to the FIFO at that edge.
- `in_ready = ~reset & (fifo_level != 2^FIFO_ADDR_W)`. It is combinational from the registered count.
  - When the FIFO is full, `in_ready` is 0 even if the serialiser pops that cycle; there is no write-through at full.
- FIFO: circular buffer with wrapping read and write pointers and an explicit count register.
  - Simultaneous push and pop leaves the count unchanged.
- Serialiser FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: `tx=1`. If the FIFO is non-empty, pop the head into the shift register, set `tx<=0`, clear the bit counter, and go to START.
  - START: hold for CLKS_PER_BIT cycles. At the end, drive `tx<=shift[0]` and go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. After bit 7 completes, drive `tx<=1` and go to STOP.
  - STOP: hold for CLKS_PER_BIT cycles. At the end:
    - If the FIFO is non-empty: pop, set `tx<=0`, and go to START. There is no idle gap.
    - Otherwise go to IDLE.
- Baud counter: 16-bit down-counter reloaded with CLKS_PER_BIT-1 at each bit boundary.
  - The bit-end strobe fires when the counter is 0.
- `busy = (state != IDLE) | (fifo_level != 0)`.
- Reset, including mid-frame:
  - At the reset edge: state goes to IDLE, `tx` to 1, pointers and count to 0. FIFO contents are discarded.
  - While `reset` is high, `in_ready` is 0.

## Timing
- Reset values:
  - `tx=1`, `busy=0`, `fifo_level=0`.
  - `in_ready=0` while `reset` is high, 1 on the first cycle after it deasserts.
- Latency: for a byte accepted at edge N into an empty FIFO with the FSM in IDLE, `fifo_level=1` after edge N. `tx` falls at edge N+1.
- Frame: exactly 10×CLKS_PER_BIT cycles from the `tx` falling edge to the end of STOP.
- Back-to-back: the next start bit begins on the edge immediately after the last STOP cycle.
- Throughput: one byte per 10×CLKS_PER_BIT cycles in steady state.
- Occupancy: the FIFO plus the shift register hold 17 bytes before `in_ready` drops.

## Test plan
- **Single byte:** CLKS_PER_BIT=4. Send 0x55 on an idle bus. Required: `tx` falls 1 cycle after the accepting edge, then reads 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. `busy` stays high for exactly 40 cycles, then clears.
- **Back-to-back:** CLKS_PER_BIT=4. Send 0x00 then 0xFF with continuous valid. Required: 80 contiguous frame cycles. The only high gap between the two data fields is the single stop bit.
- **Full FIFO:** CLKS_PER_BIT=100. Hold `in_valid` high with bytes 0x01..0x12.
  - Required: 17 transfers, then `in_ready=0` with `fifo_level=16`.
  - At the end of the first frame, one pop happens and `in_ready` reasserts. Byte 0x12 is accepted only then.
- **Ordering and wrap:** stream 64 random bytes with random `in_valid` gaps. Required: a decoding monitor on `tx` sees all 64 bytes in order. The pointers wrap 4 times without loss.
- **Reset mid-frame:** assert `reset` for 1 cycle during DATA bit 3 with 5 bytes queued. Required: `tx=1` and `fifo_level=0` after that edge, `busy=0`, no further frames emitted, and `in_ready=1` the next cycle.
- **Backpressure hold:** with the FIFO full, hold `in_valid` high and change `in_data` each cycle. Required: no write occurs while `in_ready=0`, and the byte present at the first ready cycle is the one stored.
